// File: rtl/pwm_sine_pkg.sv
// rtl/pwm_sine_pkg.sv - shared types, constants and duty mapping for the PWM sine sequencer
package pwm_sine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_e;

    localparam int DUTY_MID   = 128;
    localparam int QW_MAX_IDX = 63;

    // Negative half-wave (upper quadrants) maps below mid-scale; magnitude <= 127 keeps 1..255.
    function automatic logic [7:0] sine_duty(input logic neg, input logic [6:0] mag);
        logic [7:0] mid;
        mid = 8'(DUTY_MID);
        return neg ? (mid - {1'b0, mag}) : (mid + {1'b0, mag});
    endfunction

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - PWM period counter, comparator and wrap-gated duty register
module pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena_i,
    input  logic                run_i,
    input  logic                next_valid_i,
    input  logic [PWM_BITS-1:0] next_duty_i,
    output logic                wrap_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                duty_load_o,
    output logic                pwm_out_o
);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_RST = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                duty_load_q;
    logic                pwm_q;

    assign wrap_o = ena_i && run_i && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            duty_q      <= DUTY_RST;
            duty_load_q <= 1'b0;
            pwm_q       <= 1'b0;
        end else if (ena_i) begin
            if (!run_i) begin
                cnt_q       <= '0;
                pwm_q       <= 1'b0;
                duty_load_q <= 1'b0;
            end else begin
                cnt_q       <= cnt_q + PWM_BITS'(1);
                pwm_q       <= (cnt_q < duty_q);
                duty_load_q <= wrap_o && next_valid_i;
                // Duty only changes on the period boundary so no pulse is ever truncated.
                if (wrap_o && next_valid_i)
                    duty_q <= next_duty_i;
            end
        end
    end

    assign duty_o      = duty_q;
    assign duty_load_o = duty_load_q;
    assign pwm_out_o   = pwm_q;

endmodule

// File: rtl/pwm_sine_sequencer.sv
// rtl/pwm_sine_sequencer.sv - phase accumulator and LUT fetch FSM driving the PWM core
module pwm_sine_sequencer
    import pwm_sine_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int PHASE_BITS    = 16,
    parameter int LUT_ADDR_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     run,
    input  logic [7:0]               step,
    output logic                     lut_req,
    output logic [LUT_ADDR_BITS-1:0] lut_addr,
    input  logic                     lut_ack,
    input  logic [PWM_BITS-2:0]      lut_data,
    output logic [PWM_BITS-1:0]      duty,
    output logic                     duty_load,
    output logic                     pwm_out,
    output logic                     sample_miss,
    input  logic                     clr_miss
);

    seq_state_e                 state_q;
    logic [PHASE_BITS-1:0]      phase_q;
    logic [PHASE_BITS-1:0]      phase_d;
    logic                       lut_req_q;
    logic [LUT_ADDR_BITS-1:0]   lut_addr_q;
    logic                       neg_q;
    logic [PWM_BITS-1:0]        next_duty_q;
    logic                       next_valid_q;
    logic                       miss_q;
    logic                       wrap;
    logic [1:0]                 fetch_quad;
    logic [LUT_ADDR_BITS-1:0]   fetch_idx;
    logic [LUT_ADDR_BITS-1:0]   fetch_addr;

    // Fetches launched in a wrap cycle must already see the advanced phase.
    assign phase_d    = wrap ? (phase_q + PHASE_BITS'(step)) : phase_q;
    assign fetch_quad = phase_d[PHASE_BITS-1 -: 2];
    assign fetch_idx  = phase_d[PHASE_BITS-3 -: LUT_ADDR_BITS];
    assign fetch_addr = fetch_quad[0] ? (LUT_ADDR_BITS'(QW_MAX_IDX) - fetch_idx) : fetch_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            lut_req_q    <= 1'b0;
            lut_addr_q   <= '0;
            neg_q        <= 1'b0;
            next_duty_q  <= PWM_BITS'(DUTY_MID);
            next_valid_q <= 1'b0;
            miss_q       <= 1'b0;
        end else if (ena) begin
            if (clr_miss)
                miss_q <= 1'b0;
            if (!run) begin
                state_q      <= ST_IDLE;
                lut_req_q    <= 1'b0;
                next_valid_q <= 1'b0;
            end else begin
                phase_q <= phase_d;
                // A later set of next_valid (ack in the wrap cycle) overrides this consume.
                if (wrap) begin
                    if (next_valid_q)
                        next_valid_q <= 1'b0;
                    else
                        miss_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_FETCH;
                        lut_req_q  <= 1'b1;
                        lut_addr_q <= fetch_addr;
                        neg_q      <= fetch_quad[1];
                    end
                    ST_FETCH: begin
                        if (lut_ack) begin
                            next_duty_q  <= sine_duty(neg_q, lut_data);
                            next_valid_q <= 1'b1;
                            lut_req_q    <= 1'b0;
                            state_q      <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (wrap) begin
                            state_q    <= ST_FETCH;
                            lut_req_q  <= 1'b1;
                            lut_addr_q <= fetch_addr;
                            neg_q      <= fetch_quad[1];
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .run_i        (run),
        .next_valid_i (next_valid_q),
        .next_duty_i  (next_duty_q),
        .wrap_o       (wrap),
        .duty_o       (duty),
        .duty_load_o  (duty_load),
        .pwm_out_o    (pwm_out)
    );

    assign lut_req     = lut_req_q;
    assign lut_addr    = lut_addr_q;
    assign sample_miss = miss_q;

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// tb/tb_pwm_sine_sequencer.sv - directed self-checking bench for pwm_sine_sequencer
module tb_pwm_sine_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic [7:0] step;
    logic       lut_req;
    logic [5:0] lut_addr;
    logic       lut_ack;
    logic [6:0] lut_data;
    logic [7:0] duty;
    logic       duty_load;
    logic       pwm_out;
    logic       sample_miss;
    logic       clr_miss;

    int n_cmp;
    int n_err;
    int lat;
    int lut_mode;
    int wait_cnt;
    int hi;
    logic ack_block;

    pwm_sine_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .run         (run),
        .step        (step),
        .lut_req     (lut_req),
        .lut_addr    (lut_addr),
        .lut_ack     (lut_ack),
        .lut_data    (lut_data),
        .duty        (duty),
        .duty_load   (duty_load),
        .pwm_out     (pwm_out),
        .sample_miss (sample_miss),
        .clr_miss    (clr_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] lut_val(input logic [5:0] a);
        case (lut_mode)
            0:       return 7'd0;
            1:       return {a, 1'b0};
            2:       return 7'd127;
            default: return 7'd100;
        endcase
    endfunction

    // LUT model: ack one cycle wide, lat cycles after lut_req is seen high.
    initial begin
        lut_ack  = 1'b0;
        lut_data = 7'd0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (lut_ack) begin
                lut_ack  = 1'b0;
                wait_cnt = 0;
            end else if (lut_req && !ack_block) begin
                wait_cnt = wait_cnt + 1;
                if (wait_cnt >= lat) begin
                    lut_ack  = 1'b1;
                    lut_data = lut_val(lut_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [7:0] s, input int l, input int mode, input logic blk);
        @(negedge clk);
        rst_n     = 1'b0;
        run       = 1'b0;
        ena       = 1'b1;
        clr_miss  = 1'b0;
        step      = s;
        lat       = l;
        lut_mode  = mode;
        ack_block = blk;
        cycles(2);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        run       = 1'b0;
        step      = 8'd0;
        clr_miss  = 1'b0;
        lat       = 1;
        lut_mode  = 0;
        ack_block = 1'b0;

        cycles(1);
        check("rst_duty", 32'(duty), 32'd128);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_req", 32'(lut_req), 32'd0);
        check("rst_addr", 32'(lut_addr), 32'd0);
        check("rst_load", 32'(duty_load), 32'd0);
        check("rst_miss", 32'(sample_miss), 32'd0);

        // Flat LUT: 50% duty, high 128 of 256 cycles
        restart(8'd0, 1, 0, 1'b0);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        check("flat_high_cnt", 32'(hi), 32'd128);
        check("flat_load", 32'(duty_load), 32'd1);
        check("flat_duty", 32'(duty), 32'd128);
        check("flat_miss", 32'(sample_miss), 32'd0);

        // step 0x40, latency 2, LUT[i]=2i
        restart(8'h40, 2, 1, 1'b0);
        cycles(256);
        check("s40_load1", 32'(duty_load), 32'd1);
        check("s40_duty1", 32'(duty), 32'd128);
        cycles(1);
        check("s40_pulse_end", 32'(duty_load), 32'd0);
        check("s40_addr_w1", 32'(lut_addr), 32'd0);
        cycles(767);
        check("s40_req_w4", 32'(lut_req), 32'd1);
        check("s40_addr_w4", 32'(lut_addr), 32'd1);
        cycles(255);
        check("s40_pre_wrap_load", 32'(duty_load), 32'd0);
        check("s40_pre_wrap_duty", 32'(duty), 32'd128);
        cycles(1);
        check("s40_w5_load", 32'(duty_load), 32'd1);
        check("s40_w5_duty", 32'(duty), 32'd130);

        // Quadrant mapping with step 255 and full-scale LUT
        restart(8'd255, 1, 2, 1'b0);
        cycles(256 * 65);
        check("q1_req", 32'(lut_req), 32'd1);
        check("q1_addr", 32'(lut_addr), 32'd63);
        cycles(256);
        check("q1_duty", 32'(duty), 32'd255);
        check("q1_load", 32'(duty_load), 32'd1);
        cycles(256 * 63);
        check("q2_addr", 32'(lut_addr), 32'd0);
        check("q1b_duty", 32'(duty), 32'd255);
        cycles(256);
        check("q2_duty", 32'(duty), 32'd1);
        cycles(256 * 63);
        check("q3_addr", 32'(lut_addr), 32'd63);
        cycles(256);
        check("q3_duty", 32'(duty), 32'd1);

        // Withheld ack: miss at first wrap, clr_miss loses to a simultaneous set
        restart(8'd0, 1, 3, 1'b1);
        cycles(255);
        clr_miss = 1'b1;
        cycles(1);
        clr_miss = 1'b0;
        check("miss_set_wins", 32'(sample_miss), 32'd1);
        check("miss_duty_hold", 32'(duty), 32'd128);
        check("miss_no_load", 32'(duty_load), 32'd0);
        check("miss_req_held", 32'(lut_req), 32'd1);
        cycles(44);
        check("miss_req_300", 32'(lut_req), 32'd1);
        check("miss_addr_300", 32'(lut_addr), 32'd0);
        ack_block = 1'b0;
        cycles(211);
        check("late_pre_duty", 32'(duty), 32'd128);
        check("late_pre_load", 32'(duty_load), 32'd0);
        cycles(1);
        check("late_duty", 32'(duty), 32'd228);
        check("late_load", 32'(duty_load), 32'd1);
        check("miss_sticky", 32'(sample_miss), 32'd1);
        clr_miss = 1'b1;
        cycles(1);
        clr_miss = 1'b0;
        check("miss_cleared", 32'(sample_miss), 32'd0);

        // run=0 mid-fetch, then resume at the same address
        restart(8'd255, 1, 3, 1'b0);
        cycles(510);
        ack_block = 1'b1;
        cycles(2);
        check("stop_pre_req", 32'(lut_req), 32'd1);
        check("stop_pre_addr", 32'(lut_addr), 32'd1);
        check("stop_pre_load", 32'(duty_load), 32'd1);
        cycles(8);
        run = 1'b0;
        cycles(1);
        check("stop_req", 32'(lut_req), 32'd0);
        check("stop_pwm", 32'(pwm_out), 32'd0);
        check("stop_duty", 32'(duty), 32'd228);
        cycles(1);
        run       = 1'b1;
        ack_block = 1'b0;
        step      = 8'd0;
        cycles(1);
        check("resume_req", 32'(lut_req), 32'd1);
        check("resume_addr", 32'(lut_addr), 32'd1);
        cycles(254);
        check("resume_pre_wrap", 32'(duty_load), 32'd0);
        ack_block = 1'b1;
        cycles(1);
        check("resume_wrap", 32'(duty_load), 32'd1);

        // ena=0 for 50 cycles delays the period end by 50
        cycles(22);
        ena = 1'b0;
        cycles(50);
        check("frz_req", 32'(lut_req), 32'd1);
        check("frz_pwm", 32'(pwm_out), 32'd1);
        check("frz_miss", 32'(sample_miss), 32'd0);
        ena = 1'b1;
        cycles(233);
        check("frz_pre_wrap", 32'(sample_miss), 32'd0);
        cycles(1);
        check("frz_late_wrap", 32'(sample_miss), 32'd1);

        // Asynchronous reset mid-fetch, checked before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(lut_req), 32'd0);
        check("arst_addr", 32'(lut_addr), 32'd0);
        check("arst_duty", 32'(duty), 32'd128);
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_miss", 32'(sample_miss), 32'd0);
        check("arst_load", 32'(duty_load), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_sine_sequencer.md
Name: pwm_sine_sequencer

Overview:
- Controller that sequences the PWM sinewave datapath.
- Runs the PWM period counter and a phase accumulator, and fetches quarter-wave sine magnitudes from an external LUT over a req/ack handshake.
- Turns each magnitude into a bipolar duty value and loads it into the PWM comparator only at period wrap, giving glitch-free duty changes.
- Sits between the top-level wrapper (ui_in supplies step/run) and the sine LUT / PWM output pin.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty.
- PHASE_BITS, 16, phase accumulator width.
- LUT_ADDR_BITS, 6, quarter-wave LUT address width (64 entries).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; 0 freezes all state (no counting, no FSM moves, outputs hold).
- run  in  1  1 = generate waveform; 0 = stop and park.
- step  in  8  phase increment applied once per PWM period; zero-extended to PHASE_BITS.
- lut_req  out  1  sample request.
- lut_addr  out  LUT_ADDR_BITS  quarter-wave index; stable while lut_req=1.
- lut_ack  in  1  LUT response valid; lut_data is sampled in the same cycle.
- lut_data  in  PWM_BITS-1  magnitude, 0..127.
- duty  out  PWM_BITS  currently applied duty.
- duty_load  out  1  one-cycle pulse when duty updates.
- pwm_out  out  1  registered PWM output, 1 while cnt < duty.
- sample_miss  out  1  sticky flag: a period wrapped with no fresh sample.
- clr_miss  in  1  synchronous clear of sample_miss.

Behaviour:
- Reset values: cnt=0, phase=0, duty=128, next_duty=128, next_valid=0, lut_req=0, lut_addr=0, duty_load=0, pwm_out=0, sample_miss=0, FSM=IDLE.
- PWM counter:
  - When ena&run, cnt increments mod 2^PWM_BITS.
  - pwm_out registers (cnt<duty), so it lags cnt by one cycle.
  - duty=0 gives constant 0; duty=255 gives high 255 of every 256 cycles.
- Wrap is the cycle with cnt==255 and ena&run. In that cycle:
  - If next_valid: duty<=next_duty, duty_load=1 next cycle, next_valid<=0.
  - Else: duty holds and sample_miss<=1.
  - phase<=phase+step, with modulo 2^PHASE_BITS wrap-around.
- Sine mapping uses quadrant q=phase[15:14] and idx=phase[13:8]:
  - lut_addr = q[0] ? 63-idx : idx.
  - next_duty = q[1] ? 128-lut_data : 128+lut_data. Range is 1..255, so no overflow.
- FSM states IDLE, FETCH, HOLD:
  - IDLE -> FETCH when ena&run.
  - FETCH: lut_req=1 with lut_addr computed from the current phase. On lut_ack, latch next_duty, set next_valid=1, drop lut_req the next cycle, and go to HOLD.
  - HOLD -> FETCH the cycle after a wrap, so the fetch uses the updated phase.
  - Any state -> IDLE when run=0.
- Handshake rules:
  - lut_req deasserts only on ack or run=0.
  - lut_addr never changes while lut_req=1.
  - Acks seen outside FETCH are ignored.
  - If ack is still pending at wrap, the miss is recorded. The fetch continues with its already-latched address and the result loads at the following wrap.
- Simultaneous events:
  - Ack in the wrap cycle: the wrap load uses the old next_valid; the new sample becomes next_valid for the following period.
  - clr_miss together with a new miss: set wins.
- run=0 (while ena=1), next cycle:
  - cnt=0, pwm_out=0, lut_req=0, next_valid=0, FSM=IDLE.
  - phase and duty hold, so resume is phase-continuous.
- ena=0 freezes everything, including a pending lut_req.
- Reset mid-fetch returns all state to reset values immediately.

Decomposition:
- Shared package pwm_sine_pkg holds:
  - FSM state enum {IDLE, FETCH, HOLD}.
  - Constants DUTY_MID=128, QW_MAX_IDX=63.
  - A function mapping (quadrant, magnitude) to duty.
- One sub-module is natural: pwm_core, holding the counter, compare and registered pwm_out, with the duty load input gated to wrap. The sequencer FSM and phase accumulator stay in the top.

Test Plan:
- Reset, run=1, step=0, LUT returns 0 with ack 1 cycle after req -> duty stays 128; pwm_out high 128 of every 256 cycles; sample_miss=0.
- step=64 (0x40), ack latency 2, LUT[i]=2*i -> first load after reset: phase=0, addr 0, duty 128.
  - Second load: addr 0 (idx = phase[13:8] = 0 until phase reaches 256), duty=128.
  - After 4 wraps phase=256: addr=1, duty=130. duty_load pulses exactly at cnt 255->0.
- Preset phase via step=0x40 so it reaches 0x4000 (q=1, idx 0) -> lut_addr=63; lut_data=127 gives duty=255.
  - At q=3 with lut_data=127 -> duty=1.
- Withhold lut_ack for 300 cycles -> sample_miss=1 at the first wrap, duty unchanged.
  - lut_req stays high with a stable addr.
  - Ack later -> duty loads at the next wrap.
  - clr_miss -> sample_miss=0.
- run=0 mid-FETCH -> next cycle lut_req=0, cnt=0, pwm_out=0; phase preserved.
  - run=1 -> fetch restarts at the same lut_addr.
- ena=0 for 50 cycles mid-period -> cnt, pwm_out and lut_req frozen; resuming completes the period 50 cycles late.
- Assert rst_n low asynchronously during FETCH -> all outputs at reset values before the next clk edge.
